// File: rtl/int_perceptron_trainer.sv
// Sequential perceptron trainer: runs the learning rule over a latched 4-sample set,
// epoch by epoch, and publishes Q4.12 weights for the integer inference path.
module int_perceptron_trainer #(
   parameter int TAM        = 16,
   parameter int MAX_EPOCHS = 100,
   parameter int EPOCH_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [4*TAM-1:0]   in1,
   input  logic [4*TAM-1:0]   in2,
   input  logic [3:0]         d,
   input  logic [TAM-1:0]     eta,
   input  logic [TAM-1:0]     w0_init,
   input  logic [TAM-1:0]     w1_init,
   input  logic [TAM-1:0]     w2_init,
   output logic [TAM-1:0]     w0,
   output logic [TAM-1:0]     w1,
   output logic [TAM-1:0]     w2,
   output logic               busy,
   output logic               done,
   output logic               converged,
   output logic [EPOCH_W-1:0] epochs
);

   localparam int FRAC = 12;

   typedef enum logic [2:0] {StIdle, StInit, StEval, StUpdate, StEndEpoch, StDone} state_t;

   state_t             state;
   logic [4*TAM-1:0]   in1_q, in2_q;
   logic [3:0]         d_q;
   logic [TAM-1:0]     eta_q, w0_init_q, w1_init_q, w2_init_q;
   logic [TAM-1:0]     v;
   logic [1:0]         k;
   logic               err;

   logic [TAM-1:0]     x1, x2, dw1, dw2;
   logic               y, wrong;
   logic [EPOCH_W-1:0] epochs_inc;

   // Full-width signed product, keep bits [FRAC+TAM-1:FRAC] (wraps on overflow).
   function automatic logic [TAM-1:0] qmul(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
      logic signed [2*TAM-1:0] p;
      p = $signed({{TAM{a[TAM-1]}}, a}) * $signed({{TAM{b[TAM-1]}}, b});
      return p[FRAC +: TAM];
   endfunction

   always_comb begin
      x1         = in1_q[TAM*k +: TAM];
      x2         = in2_q[TAM*k +: TAM];
      dw1        = qmul(eta_q, x1);
      dw2        = qmul(eta_q, x2);
      y          = ~v[TAM-1];
      wrong      = (d_q[k] != y);
      epochs_inc = epochs + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         in1_q     <= '0;
         in2_q     <= '0;
         d_q       <= '0;
         eta_q     <= '0;
         w0_init_q <= '0;
         w1_init_q <= '0;
         w2_init_q <= '0;
         v         <= '0;
         k         <= '0;
         err       <= 1'b0;
         w0        <= '0;
         w1        <= '0;
         w2        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         converged <= 1'b0;
         epochs    <= '0;
      end else begin
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  in1_q     <= in1;
                  in2_q     <= in2;
                  d_q       <= d;
                  eta_q     <= eta;
                  w0_init_q <= w0_init;
                  w1_init_q <= w1_init;
                  w2_init_q <= w2_init;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  converged <= 1'b0;
                  state     <= StInit;
               end
            end
            StInit: begin
               w0     <= w0_init_q;
               w1     <= w1_init_q;
               w2     <= w2_init_q;
               k      <= '0;
               err    <= 1'b0;
               epochs <= '0;
               state  <= StEval;
            end
            StEval: begin
               v     <= w0 + qmul(w1, x1) + qmul(w2, x2);
               state <= StUpdate;
            end
            StUpdate: begin
               if (wrong) begin
                  err <= 1'b1;
                  // d=1 with y=0 means e=+1; the only other mismatch is e=-1.
                  if (d_q[k]) begin
                     w0 <= w0 + eta_q;
                     w1 <= w1 + dw1;
                     w2 <= w2 + dw2;
                  end else begin
                     w0 <= w0 - eta_q;
                     w1 <= w1 - dw1;
                     w2 <= w2 - dw2;
                  end
               end
               if (k == 2'd3) begin
                  state <= StEndEpoch;
               end else begin
                  k     <= k + 2'd1;
                  state <= StEval;
               end
            end
            StEndEpoch: begin
               epochs <= epochs_inc;
               if (!err) begin
                  converged <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= StDone;
               end else if (epochs_inc == EPOCH_W'(MAX_EPOCHS)) begin
                  converged <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= StDone;
               end else begin
                  err   <= 1'b0;
                  k     <= '0;
                  state <= StEval;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_int_perceptron_trainer.sv
// Self-checking bench for int_perceptron_trainer: directed sets from the test plan plus
// randomized sets, all checked against an epoch-level arithmetic model of the learning rule.
module tb_int_perceptron_trainer;

   localparam int TAM  = 16;
   localparam int MAXE = 8;
   localparam int EW   = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [4*TAM-1:0] in1 = '0, in2 = '0;
   logic [3:0]      d = '0;
   logic [TAM-1:0]  eta = '0, w0_init = '0, w1_init = '0, w2_init = '0;
   logic [TAM-1:0]  w0, w1, w2;
   logic            busy, done, converged;
   logic [EW-1:0]   epochs;

   int tests = 0;
   int fails = 0;

   logic [15:0] mw0, mw1, mw2, mfirst0, mfirst1;
   int          mep;
   logic        mconv;

   int_perceptron_trainer #(.TAM(TAM), .MAX_EPOCHS(MAXE), .EPOCH_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .d(d), .eta(eta),
      .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
      .w0(w0), .w1(w1), .w2(w2), .busy(busy), .done(done), .converged(converged),
      .epochs(epochs)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] qm(input logic [15:0] a, input logic [15:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return 16'(p >>> 12);
   endfunction

   // Reference: whole training run on the current input set, plain arithmetic per epoch.
   task automatic model_run();
      logic [15:0] a0, a1, a2, v, x1, x2;
      int  e;
      bit  err;
      bit  first;
      first = 1;
      a0 = w0_init; a1 = w1_init; a2 = w2_init;
      mconv = 0;
      mep = MAXE;
      for (int ep = 1; ep <= MAXE; ep++) begin
         err = 0;
         for (int s = 0; s < 4; s++) begin
            x1 = in1[16*s +: 16];
            x2 = in2[16*s +: 16];
            v  = a0 + qm(a1, x1) + qm(a2, x2);
            e  = int'(d[s]) - (v[15] ? 0 : 1);
            if (e == 1) begin
               a0 += eta; a1 += qm(eta, x1); a2 += qm(eta, x2);
            end else if (e == -1) begin
               a0 -= eta; a1 -= qm(eta, x1); a2 -= qm(eta, x2);
            end
            if (e != 0) err = 1;
            if (first) begin mfirst0 = a0; mfirst1 = a1; first = 0; end
         end
         if (!err) begin
            mconv = 1;
            mep = ep;
            break;
         end
      end
      mw0 = a0; mw1 = a1; mw2 = a2;
   endtask

   // Drive start so that the next rising edge samples it (edge 0).
   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Edges from the current point until done rises; -1 if the bound expires.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 2000; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic set_or();
      in1 = {16'h1000, 16'h1000, 16'h0000, 16'h0000};
      in2 = {16'h1000, 16'h0000, 16'h1000, 16'h0000};
      d = 4'b1110;
      eta = 16'h0800;
      w0_init = '0; w1_init = '0; w2_init = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({w0, w1, w2} !== 48'h0) begin
         $display("FAIL reset_weights got %h want 0", {w0, w1, w2}); fails++;
      end
      tests++;
      if ({busy, done, converged} !== 3'b000) begin
         $display("FAIL reset_flags got %b want 000", {busy, done, converged}); fails++;
      end
      tests++;
      if (epochs !== '0) begin
         $display("FAIL reset_epochs got %0d want 0", epochs); fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_or();
      int n;
      set_or();
      model_run();
      kick();
      tests++;
      if (busy !== 1'b1) begin
         $display("FAIL or_busy got %b want 1", busy); fails++;
      end
      wait_done(n);
      tests++;
      if (n !== 37 || n !== 1 + 9 * mep) begin
         $display("FAIL or_latency got %0d want 37", n); fails++;
      end
      tests++;
      if ({converged, busy, epochs} !== {1'b1, 1'b0, 8'd4}) begin
         $display("FAIL or_status got conv=%b busy=%b ep=%0d want 1 0 4", converged, busy, epochs);
         fails++;
      end
      tests++;
      if ({w0, w1, w2} !== {16'hF800, 16'h0800, 16'h0800} || {w0, w1, w2} !== {mw0, mw1, mw2}) begin
         $display("FAIL or_weights got %h %h %h want f800 0800 0800", w0, w1, w2); fails++;
      end
   endtask

   task automatic test_xor();
      int n;
      set_or();
      d = 4'b0110;
      model_run();
      kick();
      wait_done(n);
      tests++;
      if (n !== 73) begin
         $display("FAIL xor_latency got %0d want 73", n); fails++;
      end
      tests++;
      if ({converged, epochs} !== {1'b0, 8'(MAXE)}) begin
         $display("FAIL xor_status got conv=%b ep=%0d want 0 %0d", converged, epochs, MAXE);
         fails++;
      end
      tests++;
      if ({w0, w1, w2} !== {mw0, mw1, mw2}) begin
         $display("FAIL xor_weights got %h %h %h want %h %h %h", w0, w1, w2, mw0, mw1, mw2);
         fails++;
      end
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if ({busy, done} !== 2'b01) begin
         $display("FAIL xor_hold got busy=%b done=%b want 0 1", busy, done); fails++;
      end
   endtask

   task automatic test_all_ones();
      int n;
      in1 = {$urandom, $urandom};
      in2 = {$urandom, $urandom};
      d = 4'b1111;
      eta = 16'h1000;
      w0_init = '0; w1_init = '0; w2_init = '0;
      kick();
      wait_done(n);
      tests++;
      if (n !== 10) begin
         $display("FAIL ones_latency got %0d want 10", n); fails++;
      end
      tests++;
      if ({converged, epochs, w0, w1, w2} !== {1'b1, 8'd1, 48'h0}) begin
         $display("FAIL ones_result got conv=%b ep=%0d w=%h %h %h want 1 1 0 0 0",
                  converged, epochs, w0, w1, w2);
         fails++;
      end
   endtask

   task automatic test_wrap();
      int n;
      // w0 = 7.5 with zero inputs: v positive, d=0 -> subtract eta.
      in1 = {$urandom, 16'h0000};
      in2 = {$urandom, 16'h0000};
      d = {$urandom_range(0, 7), 1'b0};
      eta = 16'h1000;
      w0_init = 16'h7800; w1_init = $urandom; w2_init = $urandom;
      model_run();
      kick();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (w0 !== 16'h6800 || w0 !== mfirst0) begin
         $display("FAIL wrap_first got %h want 6800", w0); fails++;
      end
      wait_done(n);
      tests++;
      if ({w0, w1, w2, epochs, converged} !== {mw0, mw1, mw2, 8'(mep), mconv}) begin
         $display("FAIL wrap_run1 got %h %h %h ep=%0d want %h %h %h ep=%0d",
                  w0, w1, w2, epochs, mw0, mw1, mw2, mep);
         fails++;
      end
      // w0 = -8.0 plus 4.0*2.0 wraps v to exactly 0 -> y=1, e=-1, w0 wraps to +7.0.
      in1 = {$urandom, 16'h2000};
      in2 = {$urandom, 16'h0000};
      w0_init = 16'h8000; w1_init = 16'h4000;
      model_run();
      kick();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({w0, w1} !== {16'h7000, 16'h2000} || {w0, w1} !== {mfirst0, mfirst1}) begin
         $display("FAIL wrap_second got w0=%h w1=%h want 7000 2000", w0, w1); fails++;
      end
      wait_done(n);
      tests++;
      if ({w0, w1, w2, epochs, converged} !== {mw0, mw1, mw2, 8'(mep), mconv}) begin
         $display("FAIL wrap_run2 got %h %h %h ep=%0d want %h %h %h ep=%0d",
                  w0, w1, w2, epochs, mw0, mw1, mw2, mep);
         fails++;
      end
   endtask

   task automatic test_start_ignored();
      int n;
      set_or();
      model_run();
      kick();
      in1 = {$urandom, $urandom};
      eta = $urandom;
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      tests++;
      if (n < 0 || n + 6 !== 37) begin
         $display("FAIL ignore_latency got %0d want 37", n + 6); fails++;
      end
      tests++;
      if ({w0, w1, w2, epochs, converged} !== {mw0, mw1, mw2, 8'(mep), mconv}) begin
         $display("FAIL ignore_result got %h %h %h ep=%0d want %h %h %h ep=%0d",
                  w0, w1, w2, epochs, mw0, mw1, mw2, mep);
         fails++;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      set_or();
      kick();
      repeat (13) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({w0, w1, w2, busy, done, converged, epochs} !== '0) begin
         $display("FAIL midreset_clear got w=%h %h %h b=%b d=%b c=%b ep=%0d want all 0",
                  w0, w1, w2, busy, done, converged, epochs);
         fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_or();
      model_run();
      kick();
      wait_done(n);
      tests++;
      if (n !== 37 || {w0, w1, w2} !== {16'hF800, 16'h0800, 16'h0800} ||
          {converged, epochs} !== {1'b1, 8'd4}) begin
         $display("FAIL midreset_rerun got n=%0d w=%h %h %h ep=%0d want 37 f800 0800 0800 4",
                  n, w0, w1, w2, epochs);
         fails++;
      end
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 8; r++) begin
         in1 = {$urandom, $urandom};
         in2 = {$urandom, $urandom};
         d = 4'($urandom);
         eta = 16'($urandom_range(16'h0100, 16'h1800));
         w0_init = $urandom; w1_init = $urandom; w2_init = $urandom;
         model_run();
         kick();
         wait_done(n);
         tests++;
         if (n !== 1 + 9 * mep || {converged, epochs} !== {mconv, 8'(mep)}) begin
            $display("FAIL rand%0d_status got n=%0d conv=%b ep=%0d want n=%0d conv=%b ep=%0d",
                     r, n, converged, epochs, 1 + 9 * mep, mconv, mep);
            fails++;
         end
         tests++;
         if ({w0, w1, w2} !== {mw0, mw1, mw2}) begin
            $display("FAIL rand%0d_weights got %h %h %h want %h %h %h",
                     r, w0, w1, w2, mw0, mw1, mw2);
            fails++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_or();
      test_xor();
      test_all_ones();
      test_wrap();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/int_perceptron_trainer.md
Name: int_perceptron_trainer

Overview:
- Sequential training engine for the 2-input fixed-point perceptron; the weight-producing side of the integer inference datapath.
- Runs the perceptron learning rule over a latched 4-sample training set, epoch by epoch, until an epoch produces no errors or an epoch limit is reached.
- Publishes the trained w0/w1/w2 in the same Q4.12 signed format the integer inference path consumes (1.0 = 16'h1000).

Parameters:
- TAM, 16, data/weight width; Q4.12 signed two's complement (1 sign, 3 integer, 12 fraction bits).
- MAX_EPOCHS, 100, epoch limit before giving up (must be 1..2^EPOCH_W-1).
- EPOCH_W, 8, width of the epoch counter output.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin training; accepted only in IDLE or DONE.
- in1  in  4*TAM  x1 of samples 0..3; sample k in bits [TAM*k+TAM-1 : TAM*k].
- in2  in  4*TAM  x2 of samples 0..3, same packing.
- d  in  4  target class per sample; d[k]=1 means 1.0, d[k]=0 means 0.
- eta  in  TAM  learning rate, Q4.12.
- w0_init, w1_init, w2_init  in  TAM each  initial weights.
- w0, w1, w2  out  TAM each  current weights (registered).
- busy  out  1  high from INIT through END_EPOCH.
- done  out  1  high in DONE; held until next accepted start.
- converged  out  1  valid while done; 1 = last epoch had zero errors.
- epochs  out  EPOCH_W  number of epochs completed.

Behaviour:
- Reset: state=IDLE; w0/w1/w2=0; busy=0; done=0; converged=0; epochs=0; latched sample registers=0. Reset during a run aborts immediately; no partial result is retained.
- Start edge: in1, in2, d, eta and w*_init are latched. Inputs may change afterwards without effect. start while busy is ignored.
- FSM:
  - IDLE/DONE --start--> INIT.
  - INIT: load weights from w*_init; clear k, the error flag and epochs -> EVAL.
  - EVAL (sample k): register v = w0 + w1*x1[k] + w2*x2[k] -> UPDATE.
  - UPDATE: y = (v[TAM-1]==0) ? 1.0 : 0; e = d[k] - y.
    - If e=+1: w0+=eta, w1+=trunc(eta*x1), w2+=trunc(eta*x2).
    - If e=-1: subtract the same terms.
    - If e=0: weights unchanged.
    - Any nonzero e sets the error flag.
    - Then k<3 -> k+1, EVAL; k=3 -> END_EPOCH.
  - END_EPOCH: epochs+1.
    - Error flag clear -> DONE with converged=1.
    - Else if new epochs==MAX_EPOCHS -> DONE with converged=0.
    - Else clear the flag, k=0 -> EVAL.
- Arithmetic:
  - Q-multiply: full 2*TAM signed product, arithmetic shift right 12, keep low TAM bits (bits [27:12]).
  - All adds/subtracts wrap modulo 2^TAM; no saturation.
  - v treats exactly 0 as non-negative (y=1.0).
- Timing: 2 cycles per sample; epoch = 9 cycles.
  - done rises 1+9*E rising edges after the edge that samples start (E = epochs run).
  - busy falls on the same edge that done rises.
  - w0/w1/w2 update only on UPDATE edges and on the INIT load.

Test Plan:
- OR set, samples (x1,x2,d): (0,0,0),(0,1,1),(1,0,1),(1,1,1); init weights 0, eta=16'h0800 -> done after 37 edges, converged=1, epochs=4, w0=16'hF800, w1=16'h0800, w2=16'h0800.
- XOR set (0,0,0),(0,1,1),(1,0,1),(1,1,0), MAX_EPOCHS=8, eta=16'h0800 -> done after 73 edges, converged=0, epochs=8; busy low and done high thereafter.
- All d=1, init weights 0, eta=16'h1000 -> converged after 10 edges, epochs=1, weights stay 0.
- Wrap: w0_init=16'h7800, eta=16'h1000, sample 0 d=0 -> after first UPDATE w0=16'h6800; with w0_init=16'h8000 and an e=-1 update, w0 wraps to 16'h7000.
- start pulsed mid-run and in1 changed after start -> no restart; results match the undisturbed run.
- rst_n low during epoch 2 -> all outputs 0 immediately, IDLE; a new start then reproduces the OR result exactly.
